imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart of the byte-addressed instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and serialises each into four byte writes, big-endian (bits [31:24] at the lowest address).
- Drives a byte-wide memory write port at consecutive addresses starting at BASE_ADDR.
- Used by benches and boot logic to fill instruction memory before the core fetches.

Parameters:
- ADDR_WIDTH, 64, width of the memory byte address.
- BASE_ADDR, 0, byte address of the first byte written after each start.
- MEM_BYTES, 65536, number of bytes in the target memory; writes at or beyond BASE_ADDR+MEM_BYTES are forbidden.

Ports:
- in_clk  input  1  clock; all state changes on the rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_start  input  1  one-cycle pulse that begins a load session.
- in_word  input  32  instruction word.
- in_word_valid  input  1  in_word and in_last are valid.
- in_last  input  1  the word is the final one of the session.
- out_word_ready  output  1  loader accepts a word this cycle.
- out_mem_we  output  1  byte write strobe.
- out_mem_addr  output  ADDR_WIDTH  byte write address.
- out_mem_data  output  8  byte write data.
- out_busy  output  1  session in progress.
- out_done  output  1  session completed normally; sticky.
- out_overflow  output  1  session aborted on capacity; sticky.
- out_word_count  output  32  words fully written this session.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, all outputs 0, write pointer = BASE_ADDR.
  - out_mem_we must drop the instant in_rst_n falls, including mid-word.
  - Any partially written word is not completed after reset releases.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR:
  - out_word_ready = 0.
  - in_start takes the FSM to ACCEPT. It also clears out_done, out_overflow and out_word_count, and sets pointer = BASE_ADDR.
  - out_busy = 0 in these states.
- ACCEPT:
  - out_busy = 1.
  - Capacity check: if pointer + 4 > BASE_ADDR + MEM_BYTES, out_word_ready = 0 and the next state is ERROR, which sets out_overflow = 1.
  - Otherwise out_word_ready = 1. On in_word_valid && out_word_ready, latch in_word and in_last, clear the byte counter, and go to WRITE.
  - With no valid, remain in ACCEPT indefinitely.
- WRITE (registered outputs):
  - Lasts exactly 4 cycles, byte counter k = 0..3.
  - Each cycle: out_mem_we = 1, out_mem_addr = pointer + k, out_mem_data = word[31-8k : 24-8k].
  - out_word_ready = 0 throughout.
  - After k = 3: pointer += 4 and out_word_count += 1. Then go to DONE if the latched last = 1 (sets out_done = 1), else back to ACCEPT.
- Timing and throughput:
  - First byte write appears on the cycle after acceptance.
  - Maximum throughput is 1 word per 5 cycles.
- out_mem_we = 0 in every state other than WRITE; out_mem_addr and out_mem_data hold their last values when out_mem_we = 0.
- in_start while out_busy = 1 is ignored; the session is not restarted.
- Pointer arithmetic is ADDR_WIDTH-bit unsigned and never wraps, because the capacity check precedes every acceptance.
- out_done and out_overflow are mutually exclusive and stay asserted until the next in_start or reset.

Test Plan:
- Single word: start, then word 0x00500093 with last=1 → bytes 0x00, 0x50, 0x00, 0x93 written to addresses 0..3 on 4 consecutive cycles starting 1 cycle after acceptance; out_done=1, out_word_count=1, out_busy=0.
- Back-to-back: 3 words 0x11223344, 0x55667788, 0xDEADBEEF with valid held high, last on the third → 12 byte writes at addresses 0..11 in order; acceptances 5 cycles apart; out_word_count=3.
- Valid gaps: insert 7 idle cycles between words → ready held high during the gap, no writes during the gap, addresses continue at 4.
- Overflow: MEM_BYTES=8, send 3 words, no last → 8 bytes written; on the 3rd attempt ready stays 0, out_overflow=1, out_done=0, out_word_count=2, no write to address 8.
- Start while busy: pulse in_start during WRITE of word 2 → ignored; addresses continue to 4..7 and the count is unaffected. A restart after DONE writes again from BASE_ADDR with count cleared to 0.
- Reset mid-write: assert in_rst_n=0 during byte k=1 → out_mem_we=0 immediately, state IDLE, all outputs 0; after release, no further writes until in_start.

Source files
------------

// File: rtl/imem_loader_if.sv
// Word-in / byte-out bus of the instruction-memory loader.
// master = word producer and memory observer, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  in_start;
  logic [31:0]           in_word;
  logic                  in_word_valid;
  logic                  in_last;
  logic                  out_word_ready;
  logic                  out_mem_we;
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic [7:0]            out_mem_data;
  logic                  out_busy;
  logic                  out_done;
  logic                  out_overflow;
  logic [31:0]           out_word_count;

  modport master (
    output in_start, in_word, in_word_valid, in_last,
    input  out_word_ready, out_mem_we, out_mem_addr, out_mem_data,
           out_busy, out_done, out_overflow, out_word_count
  );

  modport slave (
    input  in_start, in_word, in_word_valid, in_last,
    output out_word_ready, out_mem_we, out_mem_addr, out_mem_data,
           out_busy, out_done, out_overflow, out_word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes 32-bit words over valid/ready and writes
// them as four big-endian bytes at consecutive addresses from BASE_ADDR.
// All outputs are registered; a word occupies one ACCEPT cycle plus four
// WRITE cycles, so peak rate is one word per five cycles.
module imem_loader #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter longint unsigned       MEM_BYTES  = 65536
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR
  } state_t;

  // One bit wider than the address so BASE_ADDR+MEM_BYTES never wraps.
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(MEM_BYTES);

  // True when a whole word still fits starting at byte address p.
  function automatic logic fits(input logic [ADDR_WIDTH-1:0] p);
    return ({1'b0, p} + (ADDR_WIDTH+1)'(4)) <= LIMIT;
  endfunction

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [23:0]           rest;     // bytes still to be written, MSB first
  logic [1:0]            k;
  logic                  last_q;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            data;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [31:0]           cnt;

  // Session FSM; every output is a register updated here. The ready flag
  // entering ACCEPT already carries the capacity verdict for this pointer.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state  <= S_IDLE;
      ptr    <= BASE_ADDR;
      rest   <= '0;
      k      <= '0;
      last_q <= 1'b0;
      ready  <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      data   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.in_start) begin
            state <= S_ACCEPT;
            ptr   <= BASE_ADDR;
            ready <= fits(BASE_ADDR);
            busy  <= 1'b1;
            done  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
          end
        end
        S_ACCEPT: begin
          if (!ready) begin
            state <= S_ERROR;
            ovf   <= 1'b1;
            busy  <= 1'b0;
          end else if (bus.in_word_valid) begin
            state  <= S_WRITE;
            ready  <= 1'b0;
            k      <= '0;
            last_q <= bus.in_last;
            we     <= 1'b1;
            addr   <= ptr;
            data   <= bus.in_word[31:24];
            rest   <= bus.in_word[23:0];
          end
        end
        S_WRITE: begin
          if (k == 2'd3) begin
            we  <= 1'b0;
            ptr <= ptr + ADDR_WIDTH'(4);
            cnt <= cnt + 32'd1;
            if (last_q) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_ACCEPT;
              ready <= fits(ptr + ADDR_WIDTH'(4));
            end
          end else begin
            k    <= k + 2'd1;
            addr <= addr + ADDR_WIDTH'(1);
            data <= rest[23:16];
            rest <= {rest[15:0], 8'h00};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_word_ready = ready;
  assign bus.out_mem_we     = we;
  assign bus.out_mem_addr   = addr;
  assign bus.out_mem_data   = data;
  assign bus.out_busy       = busy;
  assign bus.out_done       = done;
  assign bus.out_overflow   = ovf;
  assign bus.out_word_count = cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a cycle table, hand sequences for overflow, gaps
// and reset, and randomized sessions checked against a byte-level model.
module tb_imem_loader;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) m ();
  imem_loader_if #(.ADDR_WIDTH(AW)) s ();

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(64'd0), .MEM_BYTES(65536)) dut_m (
    .in_clk(clk), .in_rst_n(rst_n), .bus(m.slave));
  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(64'd0), .MEM_BYTES(8)) dut_s (
    .in_clk(clk), .in_rst_n(rst_n), .bus(s.slave));

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t mq[$], sq[$], eq[$];
  int  acc_c[$];
  logic [63:0] mptr;
  int          mcnt;

  // observed byte writes, stamped with the cycle they are visible in
  always @(negedge clk) begin
    if (m.out_mem_we) mq.push_back('{cyc, m.out_mem_addr, m.out_mem_data});
    if (s.out_mem_we) sq.push_back('{cyc, s.out_mem_addr, s.out_mem_data});
  end

  typedef struct {
    logic        start, valid, last;
    logic [31:0] word;
    logic        rdy, we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        busy, done;
    logic [7:0]  cnt;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(logic st, logic v, logic [31:0] w, logic l, logic rdy,
                              logic we, logic [15:0] a, logic [7:0] d, logic b,
                              logic dn, logic [7:0] c);
    vec_t r;
    r.start = st; r.valid = v; r.word = w; r.last = l; r.rdy = rdy; r.we = we;
    r.addr = a; r.data = d; r.busy = b; r.done = dn; r.cnt = c;
    return r;
  endfunction

  function automatic logic [63:0] obs_m();
    return {m.out_word_ready, m.out_mem_we, m.out_mem_addr[15:0], m.out_mem_data,
            m.out_busy, m.out_done, m.out_overflow, m.out_word_count[7:0]};
  endfunction
  function automatic logic [63:0] obs_s();
    return {s.out_word_ready, s.out_mem_we, s.out_mem_addr[15:0], s.out_mem_data,
            s.out_busy, s.out_done, s.out_overflow, s.out_word_count[7:0]};
  endfunction
  function automatic logic [63:0] wpack(wr_t x);
    return {x.c[15:0], x.a[39:0], x.d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  task automatic start_m();
    mq.delete(); eq.delete(); acc_c.delete();
    mptr = 64'd0; mcnt = 0;
    m.in_start = 1'b1;
    @(negedge clk);
    m.in_start = 1'b0;
  endtask

  // Offer one word; model: bytes at cycles acc+1..acc+4, big-endian order.
  task automatic send_m(input logic [31:0] w, input logic l);
    int bud = 0;
    m.in_word = w; m.in_last = l; m.in_word_valid = 1'b1;
    while (!m.out_word_ready && bud < 50) begin @(negedge clk); bud++; end
    if (bud >= 50) begin
      timeout("send_ready");
      m.in_word_valid = 1'b0;
      return;
    end
    acc_c.push_back(cyc + 1);
    for (int k = 0; k < 4; k++)
      eq.push_back('{cyc + 1 + k, mptr + 64'(k), w[31-8*k -: 8]});
    mptr += 64'd4;
    mcnt++;
    @(negedge clk);
    m.in_word_valid = 1'b0;
  endtask

  task automatic verify_m(input string tag);
    int bud = 0;
    while (m.out_busy && bud < 100) begin @(negedge clk); bud++; end
    if (bud >= 100) timeout({tag, "_busy"});
    chk({tag, "_nwr"}, 64'(mq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < mq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wpack(mq[i]), wpack(eq[i]));
    chk({tag, "_end"}, {m.out_done, m.out_overflow, m.out_busy, m.out_word_count},
        {3'b100, 32'(mcnt)});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic take;
    logic [31:0] wd[3];
    int n;

    tbl[0]  = mk(1, 0, 32'h0,        0, 1, 0, 0, 8'h00, 1, 0, 0);
    tbl[1]  = mk(0, 1, 32'h00500093, 1, 0, 1, 0, 8'h00, 1, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 0, 1, 1, 8'h50, 1, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 0, 1, 2, 8'h00, 1, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 1, 3, 8'h93, 1, 0, 0);
    tbl[5]  = mk(0, 0, 32'h0,        0, 0, 0, 3, 8'h93, 0, 1, 1);
    tbl[6]  = mk(1, 0, 32'h0,        0, 1, 0, 3, 8'h93, 1, 0, 0);
    tbl[7]  = mk(0, 1, 32'h11223344, 0, 0, 1, 0, 8'h11, 1, 0, 0);
    tbl[8]  = mk(1, 0, 32'h0,        0, 0, 1, 1, 8'h22, 1, 0, 0);
    tbl[9]  = mk(0, 0, 32'h0,        0, 0, 1, 2, 8'h33, 1, 0, 0);
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 1, 3, 8'h44, 1, 0, 0);
    tbl[11] = mk(0, 0, 32'h0,        0, 1, 0, 3, 8'h44, 1, 0, 1);
    tbl[12] = mk(0, 0, 32'h0,        0, 1, 0, 3, 8'h44, 1, 0, 1);
    tbl[13] = mk(0, 1, 32'hDEADBEEF, 1, 0, 1, 4, 8'hDE, 1, 0, 1);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 1, 5, 8'hAD, 1, 0, 1);
    tbl[15] = mk(0, 0, 32'h0,        0, 0, 1, 6, 8'hBE, 1, 0, 1);
    tbl[16] = mk(0, 0, 32'h0,        0, 0, 1, 7, 8'hEF, 1, 0, 1);
    tbl[17] = mk(0, 0, 32'h0,        0, 0, 0, 7, 8'hEF, 0, 1, 2);

    m.in_start = 0; m.in_word = 0; m.in_word_valid = 0; m.in_last = 0;
    s.in_start = 0; s.in_word = 0; s.in_word_valid = 0; s.in_last = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_m", obs_m(), 64'd0);
    chk("reset_s", obs_s(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // cycle table: single word, restart after done, start while busy, gap
    for (int i = 0; i < 18; i++) begin
      m.in_start = tbl[i].start; m.in_word_valid = tbl[i].valid;
      m.in_word = tbl[i].word;   m.in_last = tbl[i].last;
      @(negedge clk);
      chk($sformatf("tbl%0d", i), obs_m(),
          64'({tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].busy,
               tbl[i].done, 1'b0, tbl[i].cnt}));
    end
    m.in_start = 0; m.in_word_valid = 0; m.in_last = 0;

    // overflow: 8-byte memory, three words offered, no last
    wd[0] = 32'hA1B2C3D4; wd[1] = 32'h0F1E2D3C; wd[2] = 32'h99887766;
    sq.delete();
    s.in_start = 1'b1;
    @(negedge clk);
    s.in_start = 1'b0;
    acc = 0;
    s.in_word = wd[0]; s.in_last = 1'b0; s.in_word_valid = 1'b1;
    repeat (30) begin
      take = s.out_word_ready;
      @(negedge clk);
      if (take) begin acc++; s.in_word = wd[acc % 3]; end
    end
    s.in_word_valid = 1'b0;
    chk("ovf_accepts", 64'(acc), 64'd2);
    chk("ovf_flags", {s.out_overflow, s.out_done, s.out_busy, s.out_word_ready}, 4'b1000);
    chk("ovf_count", s.out_word_count, 32'd2);
    chk("ovf_nwr", 64'(sq.size()), 64'd8);
    for (int i = 0; i < sq.size() && i < 8; i++)
      chk($sformatf("ovf_wr%0d", i), {sq[i].a, sq[i].d},
          {64'(i), wd[i/4][31-8*(i%4) -: 8]});

    // back-to-back with valid held high
    start_m();
    send_m(32'h11223344, 1'b0);
    send_m(32'h55667788, 1'b0);
    send_m(32'hDEADBEEF, 1'b1);
    chk("b2b_gap01", 64'(acc_c[1] - acc_c[0]), 64'd5);
    chk("b2b_gap12", 64'(acc_c[2] - acc_c[1]), 64'd5);
    verify_m("b2b");

    // 7 idle cycles between words: ready stays up, nothing is written
    start_m();
    send_m(32'hCAFEF00D, 1'b0);
    repeat (4) @(negedge clk);
    for (int g = 0; g < 7; g++) begin
      chk($sformatf("gap%0d", g), {m.out_word_ready, m.out_mem_we}, 2'b10);
      @(negedge clk);
    end
    send_m(32'h01234567, 1'b1);
    verify_m("gap");

    // randomized sessions against the model
    for (int r = 0; r < 4; r++) begin
      start_m();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if (i > 0) repeat ($urandom_range(0, 9)) @(negedge clk);
        send_m($urandom, i == n - 1);
      end
      verify_m($sformatf("rnd%0d", r));
    end

    // reset during byte 1 of a word
    start_m();
    send_m(32'h8899AABB, 1'b0);
    @(negedge clk);
    chk("pre_rst_k1", {m.out_mem_we, m.out_mem_addr[15:0], m.out_mem_data},
        {1'b1, 16'd1, 8'h99});
    #2 rst_n = 1'b0;
    #1 chk("rst_async", obs_m(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m.in_word = 32'h13579BDF; m.in_word_valid = 1'b1;
    repeat (10) @(negedge clk);
    m.in_word_valid = 1'b0;
    chk("post_rst_nwr", 64'(mq.size()), 64'd0);
    chk("post_rst_idle", obs_m(), 64'd0);
    start_m();
    send_m(32'h00500093, 1'b1);
    verify_m("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
